// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the register-file side
// (master) and the sequential ALU (slave).
interface alu_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   oper;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         use_cf;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         zero;
    logic         neg;
    logic         ovf;

    modport master (
        output in_valid, oper, a, b, c_in, use_cf, out_ready,
        input  in_ready, out_valid, sum, c_out, zero, neg, ovf
    );

    modport slave (
        input  in_valid, oper, a, b, c_in, use_cf, out_ready,
        output in_ready, out_valid, sum, c_out, zero, neg, ovf
    );
endinterface

// File: rtl/alu_seq.sv
// Registered W-bit ALU with iterative shift/multiply, a stored carry flag for
// multi-word arithmetic, and one operation in flight behind valid/ready.
module alu_seq #(
    parameter int W = 8
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(W);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] W_CNT = CW'(W);

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB, OP_RSB, OP_OR, OP_AND, OP_ANDN,
        OP_XOR, OP_XNOR, OP_SHL, OP_SHR, OP_MUL
    } op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]  count_q, count_d;
    logic           cf_q, cf_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           c_out_q, c_out_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

    logic           ci, add_c;
    logic [W-1:0]   add_x, add_y;
    logic [W:0]     add_full;
    logic [W-1:0]   add_low;
    logic [W:0]     mul_part;
    logic [2*W-1:0] mul_next;
    logic [SW-1:0]  k;
    logic           res_load, res_c, res_ovf;
    logic [W-1:0]   res_sum;

    assign ci = bus.use_cf ? cf_q : bus.c_in;
    assign k  = bus.b[SW-1:0];

    // SUB and RSB reuse the single adder by swapping/inverting its operands.
    always_comb begin
        add_x = bus.a;
        add_y = bus.b;
        add_c = ci;
        case (bus.oper)
            OP_SUB: add_y = ~bus.b;
            OP_RSB: begin
                add_x = bus.b;
                add_y = ~bus.a;
                add_c = ~ci;
            end
            default: ;
        endcase
    end

    assign add_full = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_c};
    // Top bit of the low (W-1)-bit partial sum is the carry into bit W-1.
    assign add_low  = {1'b0, add_x[W-2:0]} + {1'b0, add_y[W-2:0]} + {{(W-1){1'b0}}, add_c};

    // Multiplier in acc low half, partial product grows in the high half.
    assign mul_part = acc_q[0] ? {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q}
                               : {1'b0, acc_q[2*W-1:W]};
    assign mul_next = {mul_part, acc_q[W-1:1]};

    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        count_d  = count_q;
        cf_d     = cf_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        res_load = 1'b0;
        res_sum  = '0;
        res_c    = 1'b0;
        res_ovf  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    case (bus.oper)
                        OP_ADD, OP_SUB, OP_RSB: begin
                            res_load = 1'b1;
                            res_sum  = add_full[W-1:0];
                            res_c    = add_full[W];
                            res_ovf  = add_low[W-1] ^ add_full[W];
                            cf_d     = add_full[W];
                        end
                        OP_OR:   begin res_load = 1'b1; res_sum = bus.a | bus.b;    end
                        OP_AND:  begin res_load = 1'b1; res_sum = bus.a & bus.b;    end
                        OP_ANDN: begin res_load = 1'b1; res_sum = ~bus.a & bus.b;   end
                        OP_XOR:  begin res_load = 1'b1; res_sum = bus.a ^ bus.b;    end
                        OP_XNOR: begin res_load = 1'b1; res_sum = bus.a ~^ bus.b;   end
                        OP_SHL, OP_SHR: begin
                            if (k == '0) begin
                                res_load = 1'b1;
                                res_sum  = bus.a;
                            end else begin
                                op_d    = op_t'(bus.oper);
                                acc_d   = {{W{1'b0}}, bus.a};
                                count_d = {1'b0, k};
                                state_d = BUSY;
                            end
                        end
                        OP_MUL: begin
                            op_d    = OP_MUL;
                            acc_d   = {{W{1'b0}}, bus.b};
                            mcand_d = bus.a;
                            count_d = W_CNT;
                            state_d = BUSY;
                        end
                        default: res_load = 1'b1;
                    endcase
                end
            end
            BUSY: begin
                count_d = count_q - 1'b1;
                case (op_q)
                    OP_SHL: begin
                        acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b0};
                        res_c = acc_q[W-1];
                    end
                    OP_SHR: begin
                        acc_d = {acc_q[2*W-1:W], 1'b0, acc_q[W-1:1]};
                        res_c = acc_q[0];
                    end
                    default: begin
                        acc_d = mul_next;
                        res_c = |mul_next[2*W-1:W];
                    end
                endcase
                res_sum = acc_d[W-1:0];
                if (count_q == CW'(1)) res_load = 1'b1;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (res_load) begin
            sum_d   = res_sum;
            c_out_d = res_c;
            ovf_d   = res_ovf;
            zero_d  = (res_sum == '0);
            neg_d   = res_sum[W-1];
            state_d = DONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            acc_q   <= '0;
            mcand_q <= '0;
            count_q <= '0;
            cf_q    <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
            cf_q    <= cf_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an arithmetic reference
// model, including latency, backpressure and mid-operation reset.
module tb_alu_seq;
    localparam int     W        = 8;
    localparam longint MASK     = (longint'(1) << W) - 1;
    localparam longint SMAX     = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN     = -(longint'(1) << (W - 1));
    localparam int     MAX_WAIT = 64;

    logic clk = 1'b0;
    logic rst_n;

    alu_seq_if #(.W(W)) bus ();
    alu_seq #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    logic model_cf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
        logic [7:0]   lat;
    } res_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint to_signed(input longint v);
        return (v > SMAX) ? v - (MASK + 1) : v;
    endfunction

    function automatic res_t add_ref(input longint x, input longint y, input longint ci);
        res_t   r;
        longint u, s;
        r     = '0;
        u     = x + y + ci;
        s     = to_signed(x) + to_signed(y) + ci;
        r.sum = W'(u & MASK);
        r.c   = (u >> W) != 0;
        r.ovf = (s > SMAX) || (s < SMIN);
        r.lat = 8'd1;
        return r;
    endfunction

    function automatic res_t model(input int op, input longint x, input longint y, input longint ci);
        res_t   r;
        int     k;
        longint p;
        r     = '0;
        r.lat = 8'd1;
        k     = int'(y % W);
        case (op)
            0:  r = add_ref(x, y, ci);
            1:  r = add_ref(x, ~y & MASK, ci);
            2:  r = add_ref(y, ~x & MASK, 1 - ci);
            3:  r.sum = W'(x | y);
            4:  r.sum = W'(x & y);
            5:  r.sum = W'(~x & y & MASK);
            6:  r.sum = W'(x ^ y);
            7:  r.sum = W'(~(x ^ y) & MASK);
            8: begin
                r.sum = W'((x << k) & MASK);
                r.c   = (k == 0) ? 1'b0 : 1'((x >> (W - k)) & 1);
                r.lat = 8'(k + 1);
            end
            9: begin
                r.sum = W'(x >> k);
                r.c   = (k == 0) ? 1'b0 : 1'((x >> (k - 1)) & 1);
                r.lat = 8'(k + 1);
            end
            10: begin
                p     = x * y;
                r.sum = W'(p & MASK);
                r.c   = (p >> W) != 0;
                r.lat = 8'(W + 1);
            end
            default: r.sum = '0;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic ucf, input logic early);
        int waited = 0;
        while (bus.in_ready !== 1'b1 && waited < MAX_WAIT) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready_wait", bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.oper      = op;
        bus.a         = x;
        bus.b         = y;
        bus.c_in      = ci;
        bus.use_cf    = ucf;
        bus.out_ready = early;
        @(posedge clk); #1;
        // Scramble operands while not accepting; the DUT must ignore them.
        bus.in_valid = 1'b0;
        bus.oper     = 4'($urandom);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.c_in     = 1'($urandom);
        bus.use_cf   = 1'($urandom);
    endtask

    task automatic finish_op(input res_t exp, input int hold, input string tag);
        int   lat     = 1;
        logic busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, lat, exp.lat);
        check({tag, ".busy_rdy"}, busy_ok, 1'b1);
        check({tag, ".sum"}, bus.sum, exp.sum);
        check({tag, ".c_out"}, bus.c_out, exp.c);
        check({tag, ".zero"}, bus.zero, exp.sum == '0);
        check({tag, ".neg"}, bus.neg, exp.sum[W-1]);
        check({tag, ".ovf"}, bus.ovf, exp.ovf);
        check({tag, ".done_rdy"}, bus.in_ready, 1'b0);
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, ".hold"}, {bus.out_valid, bus.in_ready, bus.sum, bus.c_out, bus.ovf},
                      {1'b1, 1'b0, exp.sum, exp.c, exp.ovf});
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".consumed"}, {bus.out_valid, bus.in_ready}, 2'b01);
        check({tag, ".retained"}, bus.sum, exp.sum);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic ucf, input int hold, input logic early,
                          input string tag);
        res_t   exp;
        longint ci_eff;
        ci_eff = (ucf ? model_cf : ci) ? 1 : 0;
        exp    = model(int'(op), longint'(x), longint'(y), ci_eff);
        if (op <= 4'd2) model_cf = exp.c;
        issue(op, x, y, ci, ucf, early);
        finish_op(exp, hold, tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".in_ready"}, bus.in_ready, 1'b1);
        check({tag, ".out_valid"}, bus.out_valid, 1'b0);
        check({tag, ".sum"}, bus.sum, '0);
        check({tag, ".flags"}, {bus.c_out, bus.zero, bus.neg, bus.ovf}, 4'b0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.oper      = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.use_cf    = 1'b0;
        model_cf      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("reset");

        run_op(4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, "add_carry");
        run_op(4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 0, 1'b0, "add_cf");
        run_op(4'h1, 8'h05, 8'h03, 1'b1, 1'b0, 0, 1'b0, "sub");
        run_op(4'h2, 8'h03, 8'h05, 1'b0, 1'b0, 0, 1'b0, "rsb");
        run_op(4'h0, 8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0, "add_ovf");
        run_op(4'h8, 8'h81, 8'h03, 1'b0, 1'b0, 0, 1'b0, "shl3");
        run_op(4'h9, 8'h81, 8'h01, 1'b0, 1'b0, 0, 1'b0, "shr1");
        run_op(4'h8, 8'h5A, 8'h00, 1'b0, 1'b0, 0, 1'b0, "shl0");
        run_op(4'h9, 8'hC3, 8'h07, 1'b0, 1'b0, 0, 1'b1, "shr7");
        run_op(4'hA, 8'd20, 8'd20, 1'b0, 1'b0, 0, 1'b0, "mul20");
        run_op(4'hA, 8'd13, 8'd11, 1'b0, 1'b0, 0, 1'b1, "mul13");
        run_op(4'h6, 8'hA5, 8'h3C, 1'b0, 1'b0, 5, 1'b0, "xor_hold");
        run_op(4'hC, 8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0, "illegal");

        run_op(4'h0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0, "pre_rst_add");
        issue(4'hA, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_mul.busy", {bus.in_ready, bus.out_valid}, 2'b00);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        model_cf = 1'b0;
        check_reset_state("mid_rst");
        run_op(4'h0, 8'h05, 8'h06, 1'b0, 1'b1, 0, 1'b0, "post_rst_add");

        for (int i = 0; i < 200; i++) begin
            run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom),
                   1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
